// File: rtl/hms_alarm.sv
// hms_alarm: alarm stage behind the hrs/min/sec timekeeper.
// Holds a programmable alarm time (loaded over din/addr/load). It raises
// ring when the live time reaches the alarm time at second 0. The ring can
// be stopped, or snoozed a bounded number of times, and it also ends on its
// own after a fixed number of observed seconds changes.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   hrs, min, sec   live time from the timekeeper
//   din, addr, load alarm load bus (addr 2 = minute, 3 = hour)
//   en              alarm armed (level); low forces IDLE
//   stop, snooze    user pulses
//   ring, snoozing  registered state flags
//   al_hrs, al_min  programmed alarm time
module hms_alarm #(
   parameter int RING_SECS  = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] hrs,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic [5:0] din,
   input  logic [1:0] addr,
   input  logic       load,
   input  logic       en,
   input  logic       stop,
   input  logic       snooze,
   output logic       ring,
   output logic       snoozing,
   output logic [4:0] al_hrs,
   output logic [5:0] al_min
);

   typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

   state_t     state_q, state_d;
   logic [4:0] al_hrs_q, al_hrs_d, sn_h_q, sn_h_d;
   logic [5:0] al_min_q, al_min_d, sn_m_q, sn_m_d;
   logic [2:0] scnt_q, scnt_d;
   logic [5:0] rcnt_q, rcnt_d;
   logic [5:0] sec_q, sec_d;
   logic [1:0] match_q, match_d;   // [0] alarm match, [1] snooze match
   logic       ring_q, ring_d, snoozing_q, snoozing_d;

   logic       amatch, smatch, a_trig, s_trig, sec_chg;
   logic [6:0] msum;

   assign amatch  = (hrs == al_hrs_q) && (min == al_min_q) && (sec == 6'd0);
   assign smatch  = (hrs == sn_h_q) && (min == sn_m_q) && (sec == 6'd0);
   assign a_trig  = amatch & ~match_q[0];
   assign s_trig  = smatch & ~match_q[1];
   assign sec_chg = (sec != sec_q);
   assign msum    = {1'b0, min} + 7'(SNOOZE_MIN);

   always_comb begin
      state_d  = state_q;
      al_hrs_d = al_hrs_q;
      al_min_d = al_min_q;
      sn_h_d   = sn_h_q;
      sn_m_d   = sn_m_q;
      scnt_d   = scnt_q;
      rcnt_d   = rcnt_q;
      sec_d    = sec;
      match_d  = {smatch, amatch};

      // Loads are independent of the alarm state; out-of-range data is dropped.
      if (load && addr == 2'd2 && din <= 6'd59) al_min_d = din;
      if (load && addr == 2'd3 && din <= 6'd23) al_hrs_d = din[4:0];

      if (!en) begin
         state_d = IDLE;
         scnt_d  = 3'd0;
         rcnt_d  = 6'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (a_trig) begin
                  state_d = RING;
                  rcnt_d  = 6'd0;
                  scnt_d  = 3'd0;
               end
            end
            RING: begin
               if (stop) begin
                  state_d = IDLE;
                  scnt_d  = 3'd0;
               end else if (snooze) begin
                  if (scnt_q < 3'(MAX_SNOOZE)) begin
                     state_d = SNOOZE;
                     scnt_d  = scnt_q + 3'd1;
                     if (msum >= 7'd60) begin
                        sn_m_d = 6'(msum - 7'd60);
                        sn_h_d = (hrs == 5'd23) ? 5'd0 : hrs + 5'd1;
                     end else begin
                        sn_m_d = msum[5:0];
                        sn_h_d = hrs;
                     end
                  end else begin
                     // Snoozes used up: behaves as stop.
                     state_d = IDLE;
                     scnt_d  = 3'd0;
                  end
               end else if (sec_chg) begin
                  if (rcnt_q + 6'd1 == 6'(RING_SECS)) begin
                     state_d = IDLE;
                     scnt_d  = 3'd0;
                  end else begin
                     rcnt_d = rcnt_q + 6'd1;
                  end
               end
            end
            SNOOZE: begin
               if (stop) begin
                  state_d = IDLE;
                  scnt_d  = 3'd0;
               end else if (s_trig) begin
                  state_d = RING;
                  rcnt_d  = 6'd0;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      ring_d     = (state_d == RING);
      snoozing_d = (state_d == SNOOZE);
   end

   // Match history resets to 1 so a live 00:00:00 at reset does not fire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         al_hrs_q   <= 5'd0;
         al_min_q   <= 6'd0;
         sn_h_q     <= 5'd0;
         sn_m_q     <= 6'd0;
         scnt_q     <= 3'd0;
         rcnt_q     <= 6'd0;
         sec_q      <= 6'd0;
         match_q    <= 2'b11;
         ring_q     <= 1'b0;
         snoozing_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         al_hrs_q   <= al_hrs_d;
         al_min_q   <= al_min_d;
         sn_h_q     <= sn_h_d;
         sn_m_q     <= sn_m_d;
         scnt_q     <= scnt_d;
         rcnt_q     <= rcnt_d;
         sec_q      <= sec_d;
         match_q    <= match_d;
         ring_q     <= ring_d;
         snoozing_q <= snoozing_d;
      end
   end

   assign ring     = ring_q;
   assign snoozing = snoozing_q;
   assign al_hrs   = al_hrs_q;
   assign al_min   = al_min_q;

endmodule

// File: tb/tb_hms_alarm.sv
// Directed bench for hms_alarm with RING_SECS=3, SNOOZE_MIN=5, MAX_SNOOZE=3.
module tb_hms_alarm;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] hrs;
   logic [5:0] min, sec, din;
   logic [1:0] addr;
   logic       load, en, stop, snooze;
   logic       ring, snoozing;
   logic [4:0] al_hrs;
   logic [5:0] al_min;

   int n_vec = 0;
   int n_bad = 0;

   hms_alarm #(.RING_SECS(3), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
      .clk(clk), .rst(rst), .hrs(hrs), .min(min), .sec(sec),
      .din(din), .addr(addr), .load(load), .en(en), .stop(stop),
      .snooze(snooze), .ring(ring), .snoozing(snoozing),
      .al_hrs(al_hrs), .al_min(al_min)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_t(input int h, input int m, input int s);
      hrs = 5'(h); min = 6'(m); sec = 6'(s);
   endtask

   task automatic do_load(input int a, input int d);
      addr = 2'(a); din = 6'(d); load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic pulse_snooze();
      snooze = 1'b1; step(); snooze = 1'b0;
   endtask

   // Fire the 23:58 alarm from a non-matching second.
   task automatic fire_2358();
      set_t(23, 57, 59); step();
      set_t(23, 58, 0);  step();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; stop = 1'b0; snooze = 1'b0;
      load = 1'b0; addr = 2'd0; din = 6'd0;
      set_t(0, 0, 0);
      #12;
      chk("rst_ring", ring, 0);
      chk("rst_snoozing", snoozing, 0);
      chk("rst_al_hrs", al_hrs, 0);
      chk("rst_al_min", al_min, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      repeat (3) step();
      chk("no_fire_at_reset_time", ring, 0);

      // Alarm fire at 07:30
      do_load(3, 7);
      chk("load_hrs", al_hrs, 7);
      do_load(2, 30);
      chk("load_min", al_min, 30);
      set_t(7, 29, 59); step();
      chk("pre_match", ring, 0);
      set_t(7, 30, 0); step();
      chk("fire", ring, 1);

      // Held at the match point: keeps ringing, no seconds change so no timeout
      repeat (20) step();
      chk("hold_ringing", ring, 1);
      stop = 1'b1; step(); stop = 1'b0;
      chk("stop", ring, 0);
      repeat (20) step();
      chk("hold_no_retrigger", ring, 0);

      // Timeout after the third seconds change
      set_t(7, 29, 59); step();
      set_t(7, 30, 0);  step();
      chk("refire", ring, 1);
      sec = 6'd1; step();
      chk("to_sec1", ring, 1);
      sec = 6'd2; step();
      chk("to_sec2", ring, 1);
      sec = 6'd3; step();
      chk("to_sec3", ring, 0);

      // Invalid loads leave the alarm untouched
      do_load(2, 60);
      do_load(3, 24);
      do_load(1, 5);
      do_load(0, 5);
      chk("bad_load_min", al_min, 30);
      chk("bad_load_hrs", al_hrs, 7);

      // Boundary loads, then alarm 23:58
      do_load(3, 23);
      chk("load_hrs_23", al_hrs, 23);
      do_load(2, 59);
      chk("load_min_59", al_min, 59);
      do_load(2, 58);
      chk("load_min_58", al_min, 58);

      // en low blocks the trigger
      en = 1'b0;
      fire_2358();
      chk("disabled_no_fire", ring, 0);
      en = 1'b1;

      // Snooze across midnight: target 00:03
      fire_2358();
      chk("fire_2358", ring, 1);
      pulse_snooze();
      chk("sn1_ring", ring, 0);
      chk("sn1_snoozing", snoozing, 1);
      set_t(0, 2, 0); step();
      chk("sn1_wrong_min", ring, 0);
      set_t(23, 3, 0); step();
      chk("sn1_wrong_hr", ring, 0);
      set_t(0, 3, 0); step();
      chk("sn1_refire", ring, 1);
      chk("sn1_refire_snoozing", snoozing, 0);

      // Exhaustion: snoozes 2 and 3 allowed, the fourth acts as stop
      pulse_snooze();
      chk("sn2_snoozing", snoozing, 1);
      set_t(0, 7, 59); step();
      set_t(0, 8, 0);  step();
      chk("sn2_refire", ring, 1);
      pulse_snooze();
      chk("sn3_snoozing", snoozing, 1);
      set_t(0, 12, 59); step();
      set_t(0, 13, 0);  step();
      chk("sn3_refire", ring, 1);
      pulse_snooze();
      chk("sn4_ring", ring, 0);
      chk("sn4_snoozing", snoozing, 0);
      set_t(0, 17, 59); step();
      set_t(0, 18, 0);  step();
      chk("sn4_idle", ring, 0);

      // stop and snooze together: stop wins
      fire_2358();
      chk("prio_fire", ring, 1);
      stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
      chk("prio_ring", ring, 0);
      chk("prio_snoozing", snoozing, 0);

      // en low while snoozing
      fire_2358();
      pulse_snooze();
      chk("en_sn_snoozing", snoozing, 1);
      en = 1'b0; step();
      chk("en_low_snoozing", snoozing, 0);
      en = 1'b1;

      // Asynchronous reset mid-ring
      fire_2358();
      chk("arst_fire", ring, 1);
      #3 rst = 1'b1;
      #1;
      chk("arst_ring", ring, 0);
      chk("arst_al_hrs", al_hrs, 0);
      chk("arst_al_min", al_min, 0);
      rst = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/hms_alarm.md
# hms_alarm

Alarm stage downstream of the hours/minutes/seconds timekeeper. It consumes the live `hrs`/`min`/`sec` values and holds a programmable alarm time, loaded through the same `din`/`addr`/`load` bus convention as the timekeeper. When the time reaches the alarm time it raises `ring`, with a timeout, a stop control and a bounded snooze. Its output drives the buzzer/LED driver and the display status flags.

## Interface
Parameters:
- `RING_SECS`, default 60: ring duration, in observed seconds changes; legal 1..63.
- `SNOOZE_MIN`, default 5: snooze interval in minutes; legal 1..59.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; legal 1..7.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `hrs` in 5: timekeeper hours, 0..23.
- `min` in 6: timekeeper minutes, 0..59.
- `sec` in 6: timekeeper seconds, 0..59.
- `din` in 6: load data.
- `addr` in 2: load target. 2 = alarm minute, 3 = alarm hour; 0 and 1 are ignored.
- `load` in 1: write strobe, sampled each clk.
- `en` in 1: alarm armed (level).
- `stop` in 1: stop-ring pulse.
- `snooze` in 1: snooze pulse.
- `ring` out 1: alarm active.
- `snoozing` out 1: a snooze target is pending.
- `al_hrs` out 5: programmed alarm hour.
- `al_min` out 6: programmed alarm minute.

## Operation
- States: IDLE, RING, SNOOZE.
- Registers: `al_hrs`, `al_min`, snooze target `sn_h`/`sn_m`, snooze count `scnt` (3 bits), ring counter `rcnt` (6 bits), previous second `sec_q`, and match history `match_q`.

Loading:
- `load && addr==2 && din<=59` writes `al_min`.
- `load && addr==3 && din<=23` writes `al_hrs`.
- Out-of-range `din` is ignored and the register holds its value.
- Loads are accepted in every state and never alter `ring`.

Matching:
- `amatch = (hrs==al_hrs && min==al_min && sec==0)`.
- `smatch = (hrs==sn_h && min==sn_m && sec==0)`.
- A trigger is the rising edge of the match: `match & ~match_q`. A time held at the match point (timekeeper in set mode) fires once only.

Transitions:
- IDLE → RING: on an `amatch` trigger with `en=1`. Clears `rcnt` and `scnt`.
- SNOOZE → RING: on an `smatch` trigger. Clears `rcnt`; `scnt` is kept.
- RING → IDLE on `stop`. Clears `scnt`.
- RING → SNOOZE on `snooze` when `scnt<MAX_SNOOZE`:
  - `scnt` increments.
  - `sn_m = (min+SNOOZE_MIN) mod 60`, using the current `min`.
  - `sn_h` is `hrs` if no minute carry; otherwise `(hrs+1) mod 24`. 23→0 wraps.
- RING → IDLE on `snooze` when `scnt==MAX_SNOOZE`, treated as `stop`.
- RING timeout:
  - `rcnt` increments on each cycle with `sec != sec_q`.
  - When the increment would make `rcnt==RING_SECS`, go to IDLE and clear `scnt`.
- SNOOZE → IDLE on `stop`.
- Any state → IDLE when `en=0`. Clears `scnt` and `rcnt`.

Priority within one cycle:
1. `en=0`
2. `stop`
3. `snooze`
4. timeout
5. match trigger

`snooze` outside RING and `stop` in IDLE are no-ops. In SNOOZE, `amatch` is ignored.

Outputs:
- `ring` = (state==RING).
- `snoozing` = (state==SNOOZE).
- Both are registered.

## Timing
- Reset values:
  - Outputs: `ring=0`, `snoozing=0`, `al_hrs=0`, `al_min=0`.
  - State and internal: state IDLE, `sn_h=0`, `sn_m=0`, `scnt=0`, `rcnt=0`, `sec_q=0`.
  - `match_q`: both history bits reset to 1, so a live time of 00:00:00 at reset does not trigger.
- `match_q` and `sec_q` update every clk from the current inputs.
- Latency:
  - The trigger is seen in cycle N (inputs match, `match_q=0`); `ring` rises at edge N+1.
  - `stop`, `snooze` and `en` low seen in cycle N drop `ring` at edge N+1.
  - A load seen in cycle N shows on `al_hrs`/`al_min` at edge N+1. It takes part in matching from cycle N+1.
- Timeout: `ring` falls at the edge following the `RING_SECS`-th seconds change after entry.
- Reset during RING or SNOOZE returns everything to reset values immediately and asynchronously.

## Test plan
- Alarm fire:
  - Stimulus: `en=1`; load `addr=3,din=7`, then `addr=2,din=30`; drive time 07:29:59 → 07:30:00.
  - Required: `ring=1` one clk later; `al_hrs=7`, `al_min=30`.
- Invalid load:
  - Stimulus: `addr=2,din=60`, then `addr=3,din=24`.
  - Required: `al_min`/`al_hrs` unchanged; `addr=1,din=5` also changes nothing.
- Snooze with hour wrap:
  - Stimulus: alarm 23:58; ring; pulse `snooze` while `min=58`, with `SNOOZE_MIN=5`.
  - Required: `snoozing=1`, `sn_h=0`, `sn_m=3`; `ring=1` again one clk after time reaches 00:03:00.
- Snooze exhaustion:
  - Stimulus: four snooze pulses across successive rings, with `MAX_SNOOZE=3`.
  - Required: the fourth pulse gives `ring=0`, `snoozing=0`, state IDLE.
- Timeout and hold:
  - Stimulus: `RING_SECS=3`; ring, then step `sec` 0→1→2→3.
  - Required: `ring=0` after the third change.
  - Stimulus: hold time at the alarm point 20 clks.
  - Required: no retrigger.
- Priority and reset:
  - Stimulus: `stop` and `snooze` in the same cycle during RING.
  - Required: IDLE.
  - Stimulus: `en=0` in SNOOZE.
  - Required: `snoozing=0` next clk.
  - Stimulus: async `rst` mid-RING.
  - Required: `ring=0` immediately.
